// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb: ID-stage scoreboard tracking in-flight destinations to drive
// operand forwarding, load-use interlock, bubble insertion and a stall counter.
module pipe_hazard_sb #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_READY = 1,
    parameter int CNTW       = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [AW-1:0]            id_rs,
    input  logic [AW-1:0]            id_rt,
    input  logic                     id_rs_used,
    input  logic                     id_rt_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_wreg,
    input  logic                     id_m2reg,
    input  logic                     flush,
    input  logic                     ext_stall,
    input  logic [XLEN-1:0]          rf_qa,
    input  logic [XLEN-1:0]          rf_qb,
    input  logic [NSTAGE*XLEN-1:0]   stage_res,
    output logic [XLEN-1:0]          da,
    output logic [XLEN-1:0]          db,
    output logic                     stall,
    output logic                     issue,
    output logic [CNTW-1:0]          stall_cnt
);
    logic            r_v     [NSTAGE];
    logic [AW-1:0]   r_rd    [NSTAGE];
    logic            r_wreg  [NSTAGE];
    logic            r_m2reg [NSTAGE];
    logic [CNTW-1:0] r_cnt;
    logic [XLEN-1:0] w_da, w_db;
    logic            w_hza, w_hzb, w_hz;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        w_da  = rf_qa;
        w_db  = rf_qb;
        w_hza = 1'b0;
        w_hzb = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (r_v[k] && r_wreg[k] && r_rd[k] == id_rs && id_rs != '0) begin
                w_da  = stage_res[k*XLEN +: XLEN];
                w_hza = r_m2reg[k] && (k < LOAD_READY);
            end
            if (r_v[k] && r_wreg[k] && r_rd[k] == id_rt && id_rt != '0) begin
                w_db  = stage_res[k*XLEN +: XLEN];
                w_hzb = r_m2reg[k] && (k < LOAD_READY);
            end
        end
    end

    assign w_hz      = id_valid & ((id_rs_used & w_hza) | (id_rt_used & w_hzb));
    assign stall     = w_hz | ext_stall;
    assign issue     = id_valid & ~w_hz & ~flush & ~ext_stall;
    assign da        = w_da;
    assign db        = w_db;
    assign stall_cnt = r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_v[k]     <= 1'b0;
                r_rd[k]    <= '0;
                r_wreg[k]  <= 1'b0;
                r_m2reg[k] <= 1'b0;
            end
            r_cnt <= '0;
        end else if (!ext_stall) begin
            r_v[0]     <= issue;
            r_rd[0]    <= id_rd;
            r_wreg[0]  <= id_wreg & issue;
            r_m2reg[0] <= id_m2reg & issue;
            for (int k = 1; k < NSTAGE; k++) begin
                r_v[k]     <= r_v[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_wreg[k]  <= r_wreg[k-1];
                r_m2reg[k] <= r_m2reg[k-1];
            end
            if (w_hz && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_sb.sv
// tb_pipe_hazard_sb: random stimulus into three configurations of the scoreboard,
// checked against a queue-based in-flight model via a decoupled expected-value queue.
module tb_pipe_hazard_sb;
    logic        clock = 1'b0;
    logic        reset, id_valid, id_rs_used, id_rt_used, id_wreg, id_m2reg, flush, ext_stall;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] rf_qa, rf_qb;
    logic [95:0] stage_res;
    logic [31:0] da0, db0, da1, db1, da2, db2;
    logic        st0, st1, st2, is0, is1, is2;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [7:0]  cnt2;

    always #5 clock = ~clock;

    pipe_hazard_sb u_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .flush(flush), .ext_stall(ext_stall), .rf_qa(rf_qa), .rf_qb(rf_qb),
        .stage_res(stage_res), .da(da0), .db(db0), .stall(st0), .issue(is0), .stall_cnt(cnt0));

    pipe_hazard_sb #(.LOAD_READY(2), .CNTW(4)) u_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .flush(flush), .ext_stall(ext_stall), .rf_qa(rf_qa), .rf_qb(rf_qb),
        .stage_res(stage_res), .da(da1), .db(db1), .stall(st1), .issue(is1), .stall_cnt(cnt1));

    pipe_hazard_sb #(.NSTAGE(1), .LOAD_READY(1), .CNTW(8)) u_c (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .flush(flush), .ext_stall(ext_stall), .rf_qa(rf_qa), .rf_qb(rf_qb),
        .stage_res(stage_res[31:0]), .da(da2), .db(db2), .stall(st2), .issue(is2), .stall_cnt(cnt2));

    typedef struct {
        logic [4:0] rd;
        logic       wreg;
        logic       ld;
    } ent_t;

    typedef struct {
        logic [31:0] da, db, cnt;
        logic        ca, cb, st, is;
    } exp_t;

    // Index 0 of each in-flight queue is the youngest instruction (EX).
    ent_t    pipe [3][$];
    exp_t    sbq  [3][$];
    longint  cnt  [3];
    int      ns   [3] = '{3, 3, 1};
    int      lr   [3] = '{1, 2, 1};
    longint  cmax [3] = '{64'hFFFF_FFFF, 64'hF, 64'hFF};
    int      total = 0, bad = 0;

    logic [31:0] a_da [3], a_db [3], a_cnt [3];
    logic        a_st [3], a_is [3];
    assign a_da[0] = da0;  assign a_da[1] = da1;  assign a_da[2] = da2;
    assign a_db[0] = db0;  assign a_db[1] = db1;  assign a_db[2] = db2;
    assign a_st[0] = st0;  assign a_st[1] = st1;  assign a_st[2] = st2;
    assign a_is[0] = is0;  assign a_is[1] = is1;  assign a_is[2] = is2;
    assign a_cnt[0] = cnt0;
    assign a_cnt[1] = {28'd0, cnt1};
    assign a_cnt[2] = {24'd0, cnt2};

    task automatic lookup(input int i, input logic [4:0] r, input logic [31:0] rf,
                          output logic [31:0] v, output logic h);
        bit found;
        found = 0;
        v = rf;
        h = 1'b0;
        if (r != 5'd0)
            for (int a = 0; a < pipe[i].size(); a++)
                if (!found && pipe[i][a].wreg && pipe[i][a].rd == r) begin
                    found = 1;
                    v = stage_res[a*32 +: 32];
                    h = pipe[i][a].ld && (a < lr[i]);
                end
    endtask

    task automatic model(input int i);
        logic [31:0] va, vb;
        logic        ha, hb, hz;
        exp_t        e;
        ent_t        n;
        if (reset) begin
            pipe[i].delete();
            cnt[i] = 0;
        end
        lookup(i, id_rs, rf_qa, va, ha);
        lookup(i, id_rt, rf_qb, vb, hb);
        hz    = id_valid && ((id_rs_used && ha) || (id_rt_used && hb));
        e.da  = va;
        e.ca  = !ha;
        e.db  = vb;
        e.cb  = !hb;
        e.st  = hz || ext_stall;
        e.is  = id_valid && !hz && !flush && !ext_stall;
        e.cnt = cnt[i][31:0];
        sbq[i].push_back(e);
        if (!reset && !ext_stall) begin
            n.rd   = id_rd;
            n.wreg = id_wreg && e.is;
            n.ld   = id_m2reg && e.is;
            pipe[i].push_front(n);
            if (pipe[i].size() > ns[i]) void'(pipe[i].pop_back());
            if (hz && cnt[i] < cmax[i]) cnt[i]++;
        end
    endtask

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s inst%0d got=%h want=%h t=%0t", nm, i, act, want, $time);
        end
    endtask

    always @(negedge clock)
        for (int i = 0; i < 3; i++)
            if (sbq[i].size() > 0) begin
                exp_t e;
                e = sbq[i].pop_front();
                if (e.ca) chk("da", i, a_da[i], e.da);
                if (e.cb) chk("db", i, a_db[i], e.db);
                chk("stall", i, {31'd0, a_st[i]}, {31'd0, e.st});
                chk("issue", i, {31'd0, a_is[i]}, {31'd0, e.is});
                chk("stall_cnt", i, a_cnt[i], e.cnt);
            end

    initial begin
        reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_rd = 0; id_wreg = 0; id_m2reg = 0; flush = 0; ext_stall = 0;
        rf_qa = 0; rf_qb = 0; stage_res = '0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        repeat (2) @(posedge clock);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clock);
            #1;
            reset      = ($urandom % 400) == 0;
            id_valid   = ($urandom % 8) != 0;
            id_rs      = 5'($urandom % 6);
            id_rt      = 5'($urandom % 6);
            id_rs_used = ($urandom % 4) != 0;
            id_rt_used = ($urandom % 4) != 0;
            id_rd      = 5'($urandom % 6);
            id_wreg    = ($urandom % 4) != 0;
            id_m2reg   = ($urandom % 3) == 0;
            flush      = ($urandom % 12) == 0;
            ext_stall  = ($urandom % 10) == 0;
            rf_qa      = $urandom;
            rf_qb      = $urandom;
            stage_res  = {$urandom, $urandom, $urandom};
            for (int i = 0; i < 3; i++) model(i);
        end
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (sbq[0].size() + sbq[1].size() + sbq[2].size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sbq[0].size() + sbq[1].size() + sbq[2].size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_sb.md
Name: pipe_hazard_sb

Overview:
- Parametrised ID-stage scoreboard for the pipelined CPU: forwarding, load-use interlock and bubble insertion in one block.
- Tracks the destination of every in-flight instruction internally in a shift register. The datapath no longer routes per-stage rn/wreg/m2reg back into decode.
- Generalises the fixed EX/MEM/WB 4-way forward mux to NSTAGE downstream stages, configurable load-ready stage, external freeze and a stall-cycle performance counter.

Parameters:
- XLEN, 32, datapath/register width
- AW, 5, register address width (register 0 hardwired zero)
- NSTAGE, 3, tracked downstream stages (0=EX, 1=MEM, 2=WB, ...)
- LOAD_READY, 1, first stage index where load data is valid on stage_res
- CNTW, 32, stall counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  AW  source A address (inst[25:21])
- id_rt  in  AW  source B address (inst[20:16])
- id_rs_used  in  1  source A is read
- id_rt_used  in  1  source B is read
- id_rd  in  AW  destination of decode instruction
- id_wreg  in  1  decode instruction writes a register
- id_m2reg  in  1  decode instruction is a load
- flush  in  1  squash decode instruction (taken branch/jump bubble)
- ext_stall  in  1  freeze whole pipe (memory wait)
- rf_qa  in  XLEN  register-file read A
- rf_qb  in  XLEN  register-file read B
- stage_res  in  NSTAGE*XLEN  result of stage k in bits [k*XLEN +: XLEN]
- da  out  XLEN  forwarded operand A
- db  out  XLEN  forwarded operand B
- stall  out  1  hold PC and IF/ID register (wpcir = ~stall)
- issue  out  1  decode instruction enters EX this cycle
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

Behaviour:
- State: NSTAGE entries {v, rd, wreg, m2reg} plus stall_cnt. Reset clears all v, wreg, m2reg, rd and stall_cnt to 0 asynchronously.
- Match(k, r): v[k] & wreg[k] & rd[k]==r & r!=0.
- Forward select per source r:
  - Choose the lowest k with Match(k, r), i.e. the youngest writer.
  - If found and (!m2reg[k] | k>=LOAD_READY), output stage_res slice k.
  - If found but not ready, raise hazard; the output value is don't-care.
  - If none found, output rf_qa/rf_qb.
  - Register 0 always yields rf value.
- hz_stall = id_valid & ((id_rs_used & hazard A) | (id_rt_used & hazard B)).
- stall = hz_stall | ext_stall.
- issue = id_valid & ~hz_stall & ~flush & ~ext_stall.
- The outputs da, db, stall and issue are combinational; forwarding adds zero latency.
- Clock edge, ext_stall=1: all entries hold; stall_cnt holds.
- Clock edge, ext_stall=0:
  - Entry 0 <= {issue, id_rd, id_wreg & issue, id_m2reg & issue}; a stalled or flushed slot becomes a bubble.
  - Entry k <= entry k-1 for k>=1; the oldest entry retires.
- stall_cnt increments on each edge with hz_stall=1 & ext_stall=0. It saturates at all-ones and does not wrap.
- Load-use distance: a load in entry 0 with LOAD_READY=1 costs exactly 1 bubble; LOAD_READY=2 costs 2. Stalls repeat each cycle until the entry ages to LOAD_READY.
- flush and hz_stall simultaneous: no issue, stall=1; the flushed instruction is replaced by the refetched one upstream.
- Reset mid-operation: all entries invalid next cycle, forwarding reverts to rf values, counter to 0.
- NSTAGE=1 legal; LOAD_READY>=NSTAGE means a load is never forwardable and stalls until it retires.

Test Plan:
- Reset, then id_rs=3, id_rs_used=1, rf_qa=0x11 with empty scoreboard -> da=0x11, stall=0, stall_cnt=0.
- Issue add rd=5 (result 0xAA in EX next cycle), then id_rs=5 -> da=0xAA from stage 0, no stall. One cycle later with stage 1=0xAA -> still 0xAA.
- Issue two writers to r7: older in MEM=0x1, younger in EX=0x2 -> da=0x2; with id_rt=0 and an r0 writer present -> db=rf_qb.
- Default params: lw rd=4, then use of r4 -> exactly one stall cycle, issue=0 then 1, da=load data from stage 1, stall_cnt=1. With LOAD_READY=2 -> two stall cycles, stall_cnt=2.
- ext_stall=1 for 3 cycles with a hazard pending -> entries frozen, stall=1, stall_cnt unchanged; flush=1 during issue -> entry 0 bubble, later reads of that rd use rf.
- Force stall_cnt near all-ones (CNTW=4, 20 hazard cycles) -> saturates at 0xF; assert reset mid-stall -> stall_cnt=0 and stall drops immediately.
